// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory checker datapath: compare command layout,
// data modes, LFSR constants and byteenable / mismatch helpers.
package rtl_settings_pkg;

    localparam int unsigned CMP_DATA_W  = 512;
    localparam int unsigned CMP_BYTES   = CMP_DATA_W / 8;
    localparam int unsigned CMP_OFF_W   = $clog2(CMP_BYTES);
    localparam int unsigned CMP_ADDR_W  = 32;
    localparam int unsigned CMP_BURST_W = 11;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
    localparam logic [7:0] LFSR_POLY      = 8'hB8;
    localparam logic [7:0] LFSR_ZERO_SEED = 8'hFF;

    typedef enum logic {
        FIX_DATA = 1'b0,
        RND_DATA = 1'b1
    } data_mode_t;

    typedef struct packed {
        logic                   trans_type;  // 1 = read, 0 = write
        data_mode_t             data_mode;
        logic [7:0]             data_ptrn;
        logic [CMP_ADDR_W-1:0]  start_addr;
        logic [CMP_BURST_W-2:0] words_count; // beats - 1
        logic [CMP_OFF_W-1:0]   start_off;
        logic [CMP_OFF_W-1:0]   end_off;
    } cmp_struct_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_POLY)};
    endfunction

    function automatic logic [7:0] lfsr_seed(input logic [7:0] s);
        return (s == 8'h00) ? LFSR_ZERO_SEED : s;
    endfunction

    function automatic logic [CMP_BYTES-1:0] byteenable(
        input logic                 first,
        input logic                 last,
        input logic [CMP_OFF_W-1:0] start_off,
        input logic [CMP_OFF_W-1:0] end_off
    );
        logic [CMP_BYTES-1:0] be;
        logic [CMP_OFF_W-1:0] idx;
        for (int unsigned i = 0; i < CMP_BYTES; i++) begin
            idx   = CMP_OFF_W'(i);
            be[i] = (!first || (idx >= start_off)) && (!last || (idx <= end_off));
        end
        return be;
    endfunction

    function automatic logic [CMP_BYTES-1:0] check_vec(
        input logic [CMP_DATA_W-1:0] rd,
        input logic [CMP_DATA_W-1:0] expct,
        input logic [CMP_BYTES-1:0]  be
    );
        logic [CMP_BYTES-1:0] mism;
        for (int unsigned i = 0; i < CMP_BYTES; i++) begin
            mism[i] = be[i] && (rd[i*8 +: 8] != expct[i*8 +: 8]);
        end
        return mism;
    endfunction

endpackage

// File: rtl/rd_checker_data_gen.sv
// Expected-word generator: fixed byte pattern or LFSR-based pattern,
// loaded per command and advanced once per checked beat.
module rd_checker_data_gen
    import rtl_settings_pkg::*;
#(
    parameter int unsigned AMM_DATA_W = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  mode_i,
    input  logic [7:0]            seed_i,
    input  logic                  adv_i,
    output logic [AMM_DATA_W-1:0] exp_o
);

    localparam int unsigned BYTES = AMM_DATA_W / 8;

    data_mode_t mode;
    logic [7:0] ptrn;
    logic [7:0] lfsr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode <= FIX_DATA;
            ptrn <= '0;
            lfsr <= LFSR_ZERO_SEED;
        end else if (load_i) begin
            mode <= data_mode_t'(mode_i);
            ptrn <= seed_i;
            lfsr <= lfsr_seed(seed_i);
        end else if (adv_i) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_comb begin
        exp_o = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            exp_o[i*8 +: 8] = (mode == RND_DATA) ? (lfsr ^ 8'(i)) : ptrn;
        end
    end

endmodule

// File: rtl/rd_data_checker.sv
// Read-data checker: command FIFO, beat-walking FSM, two-stage compare/capture.
// Optional feature macro: RD_CHECKER_ERR_CNT_EN (mismatching-byte counter).
module rd_data_checker
    import rtl_settings_pkg::*;
#(
    parameter int unsigned AMM_DATA_W     = 512,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned AMM_BURST_W    = 11,
    parameter int unsigned CMD_FIFO_DEPTH = 4,
    parameter int unsigned ERR_CNT_W      = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          test_start_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [$bits(cmp_struct_t)-1:0] cmd_i,
    input  logic                          rd_data_valid_i,
    input  logic [AMM_DATA_W-1:0]         rd_data_i,
    output logic                          busy_o,
    output logic                          err_o,
    output logic [ADDR_W-1:0]             err_addr_o,
    output logic [7:0]                    err_data_o,
    output logic [ERR_CNT_W-1:0]          err_cnt_o,
    output logic                          orphan_o
);

    localparam int unsigned BYTES = AMM_DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned PTR_W = $clog2(CMD_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WC_W  = AMM_BURST_W - 1;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_CHECK = 1'b1;

    // ---------------- command FIFO ----------------
    cmp_struct_t      fifo_mem [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    cmp_struct_t      cmd_in, head;
    logic             empty, full, push, pop, load;
    logic             state;

    assign cmd_in = cmp_struct_t'(cmd_i);
    assign head   = fifo_mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(CMD_FIFO_DEPTH));

    assign pop  = (state == ST_IDLE) && !empty && !test_start_i;
    assign load = pop && head.trans_type;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign cmd_ready_o = !full || pop;
    assign push        = cmd_valid_i && cmd_ready_o && !test_start_i;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= cmd_in;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (test_start_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // ---------------- beat-walking FSM ----------------
    logic [WC_W-1:0]   beat_idx, last_idx;
    logic [OFF_W-1:0]  cur_start_off, cur_end_off;
    logic [ADDR_W-1:0] beat_addr;
    logic              is_beat, first_beat, last_beat, orphan_set;

    assign is_beat    = (state == ST_CHECK) && rd_data_valid_i && !test_start_i;
    assign first_beat = (beat_idx == '0);
    assign last_beat  = (beat_idx == last_idx);
    assign orphan_set = (state == ST_IDLE) && rd_data_valid_i && !test_start_i &&
                        !(!empty && head.trans_type);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            beat_idx      <= '0;
            last_idx      <= '0;
            cur_start_off <= '0;
            cur_end_off   <= '0;
            beat_addr     <= '0;
        end else if (test_start_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state         <= ST_CHECK;
                        beat_idx      <= '0;
                        last_idx      <= head.words_count;
                        cur_start_off <= head.start_off;
                        cur_end_off   <= head.end_off;
                        beat_addr     <= {head.start_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    end
                end
                default: begin
                    if (is_beat) begin
                        beat_idx  <= beat_idx + WC_W'(1);
                        beat_addr <= beat_addr + ADDR_W'(BYTES);
                        if (last_beat) state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    logic [AMM_DATA_W-1:0] exp_word;
    logic [BYTES-1:0]      be, mism;

    rd_checker_data_gen #(
        .AMM_DATA_W (AMM_DATA_W)
    ) u_data_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load),
        .mode_i (head.data_mode),
        .seed_i (head.data_ptrn),
        .adv_i  (is_beat),
        .exp_o  (exp_word)
    );

    assign be   = byteenable(first_beat, last_beat, cur_start_off, cur_end_off);
    assign mism = check_vec(rd_data_i, exp_word, be);

    // ---------------- stage 1: registered mismatch vector ----------------
    logic                  s1_valid;
    logic [BYTES-1:0]      s1_mism;
    logic [ADDR_W-1:0]     s1_addr;
    logic [AMM_DATA_W-1:0] s1_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_mism  <= '0;
            s1_addr  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= is_beat;
            s1_mism  <= mism;
            s1_addr  <= beat_addr;
            s1_data  <= rd_data_i;
        end
    end

    // ---------------- stage 2: first-error capture ----------------
    logic [OFF_W-1:0] low_idx;
    logic             low_found;
    logic             s1_hit;

    always_comb begin
        low_idx   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (s1_mism[i] && !low_found) begin
                low_found = 1'b1;
                low_idx   = OFF_W'(i);
            end
        end
    end

    assign s1_hit = s1_valid && low_found;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
            err_data_o <= '0;
            orphan_o   <= 1'b0;
        end else if (test_start_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
            err_data_o <= '0;
            orphan_o   <= 1'b0;
        end else begin
            if (orphan_set) orphan_o <= 1'b1;
            if (s1_hit) begin
                err_o <= 1'b1;
                if (!err_o) begin
                    err_addr_o <= s1_addr + ADDR_W'(low_idx);
                    err_data_o <= s1_data[{low_idx, 3'b000} +: 8];
                end
            end
        end
    end

`ifdef RD_CHECKER_ERR_CNT_EN
    localparam int unsigned POP_W = $clog2(BYTES + 1);
    localparam int unsigned SUM_W = ERR_CNT_W + 1;

    logic [POP_W-1:0]     mism_pop;
    logic [SUM_W-1:0]     cnt_sum;
    logic [ERR_CNT_W-1:0] err_cnt;

    always_comb begin
        mism_pop = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            mism_pop = mism_pop + POP_W'(s1_mism[i]);
        end
        cnt_sum = {1'b0, err_cnt} + SUM_W'(mism_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if (test_start_i) begin
            err_cnt <= '0;
        end else if (s1_valid) begin
            err_cnt <= cnt_sum[ERR_CNT_W] ? '1 : cnt_sum[ERR_CNT_W-1:0];
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = '0;
`endif

    assign busy_o = !empty || (state != ST_IDLE) || s1_valid;

endmodule
